// File: rtl/medfilt_line_buffer.sv
// Median-filter column generator: two shifting line buffers turn a raster
// stream into vertically aligned 3-pixel columns with edge-row replication.
module medfilt_line_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_sof,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_w1,
    output logic [DATA_WIDTH-1:0] out_w2,
    output logic [DATA_WIDTH-1:0] out_w3,
    output logic                  out_sof,
    output logic                  out_eol
);

    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);

    typedef enum logic [1:0] {
        S_FILL,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [XW-1:0]   fx_q, fx_d;

    logic            xfer;
    logic            flush_issue;
    logic [XW-1:0]   cur_x;
    logic [YW-1:0]   cur_y;
    logic [XW-1:0]   rd_addr;

    logic            s1_valid_d, s1_top_d, s1_flush_d, s1_sof_d, s1_eol_d;
    logic            s1_valid_q, s1_top_q, s1_flush_q, s1_sof_q, s1_eol_q;
    logic            s1_wr_q;
    logic [XW-1:0]   s1_x_q;
    logic [DATA_WIDTH-1:0] s1_pix_q;

    logic [DATA_WIDTH-1:0] lb_a [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lb_b [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] rd_a_q, rd_b_q;

    logic                  out_valid_q, out_sof_q, out_eol_q;
    logic [DATA_WIDTH-1:0] out_w1_q, out_w2_q, out_w3_q;

    // A start-of-frame pixel is re-addressed to (0,0) before anything uses it.
    always_comb begin
        in_ready    = (state_q != S_FLUSH);
        xfer        = in_valid && in_ready;
        flush_issue = (state_q == S_FLUSH);
        cur_x       = in_sof ? '0 : x_q;
        cur_y       = in_sof ? '0 : y_q;
        rd_addr     = cur_x;
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        fx_d        = fx_q;
        s1_valid_d  = 1'b0;
        s1_top_d    = 1'b0;
        s1_flush_d  = 1'b0;
        s1_sof_d    = 1'b0;
        s1_eol_d    = 1'b0;
        unique case (state_q)
            S_FILL, S_RUN: begin
                if (xfer) begin
                    s1_valid_d = (cur_y != '0);
                    s1_top_d   = (cur_y == Y_ONE);
                    s1_sof_d   = (cur_y == Y_ONE) && (cur_x == '0);
                    s1_eol_d   = (cur_y != '0) && (cur_x == X_LAST);
                    if (cur_x == X_LAST) begin
                        x_d = '0;
                        if (cur_y == Y_LAST) begin
                            y_d     = '0;
                            fx_d    = '0;
                            state_d = S_FLUSH;
                        end else begin
                            y_d     = cur_y + 1'b1;
                            state_d = S_RUN;
                        end
                    end else begin
                        x_d     = cur_x + 1'b1;
                        y_d     = cur_y;
                        state_d = (cur_y == '0) ? S_FILL : S_RUN;
                    end
                end
            end
            S_FLUSH: begin
                rd_addr    = fx_q;
                s1_valid_d = 1'b1;
                s1_flush_d = 1'b1;
                s1_eol_d   = (fx_q == X_LAST);
                if (fx_q == X_LAST) begin
                    fx_d    = '0;
                    x_d     = '0;
                    y_d     = '0;
                    state_d = S_FILL;
                end else begin
                    fx_d = fx_q + 1'b1;
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_FILL;
            x_q        <= '0;
            y_q        <= '0;
            fx_q       <= '0;
            s1_valid_q <= 1'b0;
            s1_top_q   <= 1'b0;
            s1_flush_q <= 1'b0;
            s1_sof_q   <= 1'b0;
            s1_eol_q   <= 1'b0;
            s1_wr_q    <= 1'b0;
            s1_x_q     <= '0;
            s1_pix_q   <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            fx_q       <= fx_d;
            s1_valid_q <= s1_valid_d;
            s1_top_q   <= s1_top_d;
            s1_flush_q <= s1_flush_d;
            s1_sof_q   <= s1_sof_d;
            s1_eol_q   <= s1_eol_d;
            s1_wr_q    <= xfer;
            if (xfer) begin
                s1_x_q   <= cur_x;
                s1_pix_q <= in_data;
            end
        end
    end

    // Read-before-write: the old LB_A word is captured on the accept edge and
    // lands in LB_B one cycle later, never at an address read in that cycle.
    always_ff @(posedge clk) begin
        if (xfer || flush_issue) begin
            rd_a_q <= lb_a[rd_addr];
            rd_b_q <= lb_b[rd_addr];
        end
        if (xfer) begin
            lb_a[cur_x] <= in_data;
        end
        if (s1_wr_q) begin
            lb_b[s1_x_q] <= rd_a_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
            out_w1_q    <= '0;
            out_w2_q    <= '0;
            out_w3_q    <= '0;
        end else begin
            out_valid_q <= s1_valid_q;
            out_sof_q   <= s1_sof_q;
            out_eol_q   <= s1_eol_q;
            if (s1_valid_q) begin
                out_w2_q <= rd_a_q;
                out_w1_q <= s1_top_q ? rd_a_q : rd_b_q;
                out_w3_q <= s1_flush_q ? rd_a_q : s1_pix_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_eol   = out_eol_q;
    assign out_w1    = out_w1_q;
    assign out_w2    = out_w2_q;
    assign out_w3    = out_w3_q;

endmodule

// File: tb/tb_medfilt_line_buffer.sv
// Bench for medfilt_line_buffer: directed plan scenarios plus random frames
// compared against a row-replicating window model.
`timescale 1ns/1ps
module tb_medfilt_line_buffer;

    localparam int W = 4;
    localparam int H = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_ready;
    logic       out_valid, out_sof, out_eol;
    logic [7:0] out_w1, out_w2, out_w3;

    logic       in2_valid = 1'b0;
    logic       in2_sof = 1'b0;
    logic [7:0] in2_data = 8'd0;
    logic       in2_ready;
    logic       out2_valid, out2_sof, out2_eol;
    logic [7:0] out2_w1, out2_w2, out2_w3;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int stall_cnt = 0;

    logic [25:0] got_q[$];
    logic [25:0] got2_q[$];
    int          gcyc_q[$];
    int          acc_q[$];

    medfilt_line_buffer #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sof(in_sof),
        .out_valid(out_valid), .out_w1(out_w1), .out_w2(out_w2),
        .out_w3(out_w3), .out_sof(out_sof), .out_eol(out_eol)
    );

    medfilt_line_buffer #(.DATA_WIDTH(8), .IMG_WIDTH(2), .IMG_HEIGHT(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in2_valid), .in_ready(in2_ready),
        .in_data(in2_data), .in_sof(in2_sof),
        .out_valid(out2_valid), .out_w1(out2_w1), .out_w2(out2_w2),
        .out_w3(out2_w3), .out_sof(out2_sof), .out_eol(out2_eol)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid) begin
            got_q.push_back({out_w1, out_w2, out_w3, out_sof, out_eol});
            gcyc_q.push_back(cyc);
        end
        if (out2_valid)
            got2_q.push_back({out2_w1, out2_w2, out2_w3, out2_sof, out2_eol});
        if (in_valid && in_ready)
            acc_q.push_back(cyc);
        if (!in_ready)
            stall_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    // Window model: rows clamp at the top and bottom image edges.
    function automatic void model(input logic [7:0] pix[$], output logic [25:0] e[$]);
        e = {};
        for (int c = 0; c < H; c++) begin
            for (int x = 0; x < W; x++) begin
                int rt, rb;
                rt = (c == 0) ? 0 : c - 1;
                rb = (c == H - 1) ? H - 1 : c + 1;
                e.push_back({pix[rt*W+x], pix[c*W+x], pix[rb*W+x],
                             (c == 0 && x == 0), (x == W - 1)});
            end
        end
    endfunction

    function automatic logic [25:0] got_at(input int i);
        return (i < got_q.size()) ? got_q[i] : 26'bx;
    endfunction

    function automatic int gcyc_at(input int i);
        return (i < gcyc_q.size()) ? gcyc_q[i] : -100000;
    endfunction

    function automatic int acc_at(input int i);
        return (i < acc_q.size()) ? acc_q[i] : 100000;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] d, input logic s);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = s;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            n_fail++;
            $display("FAIL push_timeout in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_checks++;
        if (out_valid !== 1'b0 || out2_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid got %b/%b required 0", out_valid, out2_valid);
        end
        n_checks++;
        if (in_ready !== 1'b1 || in2_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready got %b/%b required 1", in_ready, in2_ready);
        end
        n_checks++;
        if ({out_w1, out_w2, out_w3} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_data got %h required 0", {out_w1, out_w2, out_w3});
        end
        n_checks++;
        if ({out_sof, out_eol} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_flags got %b required 00", {out_sof, out_eol});
        end
        idle(3);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_hold got v=%b r=%b required v=0 r=1", out_valid, in_ready);
        end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_w2h2();
        logic [7:0]  p[4];
        logic [25:0] e[4];
        p[0] = 8'd9; p[1] = 8'd3; p[2] = 8'd7; p[3] = 8'd1;
        e[0] = {8'd9, 8'd9, 8'd7, 1'b1, 1'b0};
        e[1] = {8'd3, 8'd3, 8'd1, 1'b0, 1'b1};
        e[2] = {8'd9, 8'd7, 8'd7, 1'b0, 1'b0};
        e[3] = {8'd3, 8'd1, 8'd1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            in2_valid = 1'b1;
            in2_data  = p[i];
            in2_sof   = (i == 0);
            @(posedge clk);
            #1;
        end
        in2_valid = 1'b0;
        in2_sof   = 1'b0;
        idle(8);
        n_checks++;
        if (got2_q.size() !== 4) begin
            n_fail++;
            $display("FAIL w2h2_count got %0d required 4", got2_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            logic [25:0] g;
            g = (i < got2_q.size()) ? got2_q[i] : 26'bx;
            n_checks++;
            if (g !== e[i]) begin
                n_fail++;
                $display("FAIL w2h2_col%0d got %h required %h", i, g, e[i]);
            end
        end
    endtask

    task automatic test_basic();
        logic [7:0]  pix[$];
        logic [25:0] e[$];
        int g0, a0, s0;
        g0 = got_q.size(); a0 = acc_q.size(); s0 = stall_cnt;
        for (int i = 0; i < W*H; i++) pix.push_back(8'(i + 1));
        for (int i = 0; i < W*H; i++) push(pix[i], i == 0);
        idle(W + 6);
        model(pix, e);
        n_checks++;
        if (got_q.size() - g0 !== W*H) begin
            n_fail++;
            $display("FAIL basic_count got %0d required %0d", got_q.size() - g0, W*H);
        end
        for (int i = 0; i < W*H; i++) begin
            n_checks++;
            if (got_at(g0 + i) !== e[i]) begin
                n_fail++;
                $display("FAIL basic_col%0d got %h required %h", i, got_at(g0 + i), e[i]);
            end
        end
        n_checks++;
        if (stall_cnt - s0 !== W) begin
            n_fail++;
            $display("FAIL basic_stall got %0d required %0d", stall_cnt - s0, W);
        end
        for (int i = 0; i < W*(H-1); i++) begin
            n_checks++;
            if (gcyc_at(g0 + i) - acc_at(a0 + i + W) !== 2) begin
                n_fail++;
                $display("FAIL basic_lat%0d got %0d required 2", i,
                         gcyc_at(g0 + i) - acc_at(a0 + i + W));
            end
        end
        for (int j = 0; j < W; j++) begin
            n_checks++;
            if (gcyc_at(g0 + W*(H-1) + j) - acc_at(a0 + W*H - 1) !== 3 + j) begin
                n_fail++;
                $display("FAIL basic_flush_lat%0d got %0d required %0d", j,
                         gcyc_at(g0 + W*(H-1) + j) - acc_at(a0 + W*H - 1), 3 + j);
            end
        end
    endtask

    task automatic test_gaps();
        logic [7:0]  pix[$];
        logic [25:0] e[$];
        int g0, a0;
        g0 = got_q.size(); a0 = acc_q.size();
        for (int i = 0; i < W*H; i++) pix.push_back(8'(i + 1));
        for (int i = 0; i < W*H; i++) begin
            push(pix[i], i == 0);
            idle(1);
        end
        idle(W + 6);
        model(pix, e);
        n_checks++;
        if (got_q.size() - g0 !== W*H) begin
            n_fail++;
            $display("FAIL gaps_count got %0d required %0d", got_q.size() - g0, W*H);
        end
        for (int i = 0; i < W*H; i++) begin
            n_checks++;
            if (got_at(g0 + i) !== e[i]) begin
                n_fail++;
                $display("FAIL gaps_col%0d got %h required %h", i, got_at(g0 + i), e[i]);
            end
        end
        for (int i = 0; i < W*(H-1); i++) begin
            n_checks++;
            if (gcyc_at(g0 + i) - acc_at(a0 + i + W) !== 2) begin
                n_fail++;
                $display("FAIL gaps_lat%0d got %0d required 2", i,
                         gcyc_at(g0 + i) - acc_at(a0 + i + W));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  p1[$], p2[$];
        logic [25:0] e1[$], e2[$], e[$];
        int g0, a0, s0;
        g0 = got_q.size(); a0 = acc_q.size(); s0 = stall_cnt;
        for (int i = 0; i < W*H; i++) begin
            p1.push_back(8'(i + 1));
            p2.push_back(8'(i + 13));
        end
        for (int i = 0; i < W*H; i++) push(p1[i], i == 0);
        for (int i = 0; i < W*H; i++) push(p2[i], i == 0);
        idle(W + 6);
        model(p1, e1);
        model(p2, e2);
        e = {e1, e2};
        n_checks++;
        if (got_q.size() - g0 !== 2*W*H) begin
            n_fail++;
            $display("FAIL b2b_count got %0d required %0d", got_q.size() - g0, 2*W*H);
        end
        for (int i = 0; i < 2*W*H; i++) begin
            n_checks++;
            if (got_at(g0 + i) !== e[i]) begin
                n_fail++;
                $display("FAIL b2b_col%0d got %h required %h", i, got_at(g0 + i), e[i]);
            end
        end
        n_checks++;
        if (acc_at(a0 + W*H) - acc_at(a0 + W*H - 1) !== W + 1) begin
            n_fail++;
            $display("FAIL b2b_gap got %0d required %0d",
                     acc_at(a0 + W*H) - acc_at(a0 + W*H - 1), W + 1);
        end
        n_checks++;
        if (stall_cnt - s0 !== 2*W) begin
            n_fail++;
            $display("FAIL b2b_stall got %0d required %0d", stall_cnt - s0, 2*W);
        end
    endtask

    task automatic test_sof_restart();
        logic [7:0]  p2[$];
        logic [25:0] e2[$], e[$];
        int g0, s0;
        g0 = got_q.size(); s0 = stall_cnt;
        for (int i = 0; i < 6; i++) push(8'(i + 1), i == 0);
        for (int i = 0; i < W*H; i++) p2.push_back(8'(i + 7));
        for (int i = 0; i < W*H; i++) push(p2[i], i == 0);
        idle(W + 6);
        model(p2, e2);
        e = {26'({8'd1, 8'd1, 8'd5, 1'b1, 1'b0}), 26'({8'd2, 8'd2, 8'd6, 1'b0, 1'b0}), e2};
        n_checks++;
        if (got_q.size() - g0 !== W*H + 2) begin
            n_fail++;
            $display("FAIL sof_count got %0d required %0d", got_q.size() - g0, W*H + 2);
        end
        for (int i = 0; i < W*H + 2; i++) begin
            n_checks++;
            if (got_at(g0 + i) !== e[i]) begin
                n_fail++;
                $display("FAIL sof_col%0d got %h required %h", i, got_at(g0 + i), e[i]);
            end
        end
        n_checks++;
        if (stall_cnt - s0 !== W) begin
            n_fail++;
            $display("FAIL sof_stall got %0d required %0d", stall_cnt - s0, W);
        end
    endtask

    task automatic test_reset_flush();
        logic [7:0]  pix[$];
        logic [25:0] e[$];
        int g0;
        for (int i = 0; i < W*H; i++) pix.push_back(8'(i + 1));
        for (int i = 0; i < W*H; i++) push(pix[i], i == 0);
        idle(2);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstflush_valid got %b required 0", out_valid);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstflush_ready got %b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);
        g0 = got_q.size();
        for (int i = 0; i < W*H; i++) push(pix[i], i == 0);
        idle(W + 6);
        model(pix, e);
        n_checks++;
        if (got_q.size() - g0 !== W*H) begin
            n_fail++;
            $display("FAIL rstflush_count got %0d required %0d", got_q.size() - g0, W*H);
        end
        for (int i = 0; i < W*H; i++) begin
            n_checks++;
            if (got_at(g0 + i) !== e[i]) begin
                n_fail++;
                $display("FAIL rstflush_col%0d got %h required %h", i, got_at(g0 + i), e[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0]  pix[$];
        logic [25:0] ef[$], e[$];
        int g0, a0, s0;
        g0 = got_q.size(); a0 = acc_q.size(); s0 = stall_cnt;
        e = {};
        for (int f = 0; f < 3; f++) begin
            pix = {};
            for (int i = 0; i < W*H; i++) pix.push_back(8'($urandom));
            for (int i = 0; i < W*H; i++) begin
                push(pix[i], i == 0);
                idle(int'($urandom_range(0, 2)));
            end
            model(pix, ef);
            e = {e, ef};
        end
        idle(W + 6);
        n_checks++;
        if (got_q.size() - g0 !== 3*W*H) begin
            n_fail++;
            $display("FAIL rand_count got %0d required %0d", got_q.size() - g0, 3*W*H);
        end
        for (int i = 0; i < 3*W*H; i++) begin
            n_checks++;
            if (got_at(g0 + i) !== e[i]) begin
                n_fail++;
                $display("FAIL rand_col%0d got %h required %h", i, got_at(g0 + i), e[i]);
            end
        end
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < W*(H-1); i++) begin
                n_checks++;
                if (gcyc_at(g0 + f*W*H + i) - acc_at(a0 + f*W*H + i + W) !== 2) begin
                    n_fail++;
                    $display("FAIL rand_lat f%0d c%0d got %0d required 2", f, i,
                             gcyc_at(g0 + f*W*H + i) - acc_at(a0 + f*W*H + i + W));
                end
            end
        end
        n_checks++;
        if (stall_cnt - s0 !== 3*W) begin
            n_fail++;
            $display("FAIL rand_stall got %0d required %0d", stall_cnt - s0, 3*W);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_w2h2();
        test_basic();
        test_gaps();
        test_back_to_back();
        test_sof_restart();
        test_reset_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/medfilt_line_buffer.md
Name: medfilt_line_buffer

Overview:
Upstream window-column generator for the median filter datapath. It takes a raster pixel stream and stores the two previous lines in on-chip line buffers. Each cycle it can emit one vertically aligned 3-pixel column (top, centre, bottom), which feeds the per-row/per-column compare sorters. Image borders are handled by edge-row replication. The final line is flushed internally after the frame's last pixel, so output row count equals input row count.

Parameters:
DATA_WIDTH, 8, pixel width in bits
IMG_WIDTH, 640, pixels per line; legal range 2..4096
IMG_HEIGHT, 480, lines per frame; legal range 2..4096

Ports:
clk  input  1  clock, all logic rising-edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  input pixel valid
in_ready  output  1  block can accept a pixel; a transfer happens when in_valid and in_ready are both high
in_data  input  DATA_WIDTH  input pixel
in_sof  input  1  marks the first pixel of a frame; sampled only on a transfer
out_valid  output  1  output column valid, single-cycle qualifier, no backpressure
out_w1  output  DATA_WIDTH  top pixel (row c-1; replicated from row c when c=0)
out_w2  output  DATA_WIDTH  centre pixel (row c)
out_w3  output  DATA_WIDTH  bottom pixel (row c+1; replicated from row c when c=IMG_HEIGHT-1)
out_sof  output  1  high with out_valid on column (x=0, c=0)
out_eol  output  1  high with out_valid on column x=IMG_WIDTH-1 of every row

Behaviour:
- Reset (asynchronous assert):
  - Outputs: out_valid, out_sof, out_eol = 0; out_w1..out_w3 = 0; in_ready = 1.
  - State goes to FILL; x, y counters = 0.
  - Line-buffer contents are undefined and never read before being written.
- Storage: two buffers, each IMG_WIDTH x DATA_WIDTH, with synchronous read. LB_A holds row y-1 and LB_B holds row y-2. On an accepted pixel at column x: read both at x, write in_data to LB_A[x], and write the old LB_A[x] to LB_B[x]. This is a shift, implemented with a read-before-write pipeline.
- Counters:
  - x increments on each transfer and wraps to 0 at IMG_WIDTH-1.
  - On wrap, y increments.
  - A transfer with in_sof=1 forces the pixel to be treated as (0,0), in any state except FLUSH. The partial frame is abandoned and nothing is flushed for it.
- States:
  - FILL (y=0): accept pixels and produce no output. Leaving column IMG_WIDTH-1 goes to RUN.
  - RUN (1 <= y <= IMG_HEIGHT-1):
    - Each transfer at (x,y) produces one output column for centre row c=y-1: w3 = in_data, w2 = LB_A[x], w1 = LB_B[x].
    - When c=0, w1 = w2.
    - A transfer at (IMG_WIDTH-1, IMG_HEIGHT-1) goes to FLUSH.
  - FLUSH:
    - in_ready = 0.
    - An internal x counter runs 0..IMG_WIDTH-1, one column per cycle, emitting centre row c=IMG_HEIGHT-1 with w2 = LB_A[x] (the just-completed row), w1 = previous row, w3 = w2.
    - Note: the last RUN pixel's write must complete before FLUSH reads column IMG_WIDTH-1. A bypass or ordering guarantee is required.
    - After column IMG_WIDTH-1 is issued, return to FILL with in_ready = 1 on the following cycle.
- Latency: out_valid is asserted exactly 2 cycles after the accepted transfer that produced it (RUN), or 2 cycles after the FLUSH issue cycle. Output is registered, and column order is strictly raster.
- Throughput: 1 column/cycle. in_valid gaps create matching out_valid gaps, shifted by 2 cycles.
- Frame accounting: IMG_WIDTH*IMG_HEIGHT columns are output per IMG_WIDTH*IMG_HEIGHT accepted pixels. Total stall per frame is exactly IMG_WIDTH cycles of in_ready = 0.
- Reset mid-frame or mid-FLUSH: immediate return to the reset state. Any in-flight outputs are dropped: out_valid is 0 from reset assertion.
- in_data, in_sof and pixels offered while in_ready = 0 are ignored and not consumed.

Test Plan:
- W=4, H=3, pixels 1..12 streamed back-to-back with in_sof on pixel 1:
  - Row 0: (1,1,5), (2,2,6), (3,3,7), (4,4,8).
  - Row 1: (1,5,9), (2,6,10), (3,7,11), (4,8,12).
  - FLUSH: (5,9,9), (6,10,10), (7,11,11), (8,12,12).
  - in_ready is low for exactly 4 cycles.
  - out_sof is set on the first column; out_eol is set on every 4th column.
- Same frame with in_valid toggled 1,0,1,0 -> identical column sequence, each column 2 cycles after its accepted pixel.
- Two consecutive frames, the second stimulus offered during FLUSH -> no pixel is consumed until in_ready = 1; the second frame's output equals the first-frame pattern with values +12.
- in_sof reasserted at pixel 7 of a W=4, H=3 frame -> pixel 7 restarts as (0,0); no flush of the old frame; the next 12 pixels produce the full 12-column pattern.
- rst pulsed during FLUSH column 2 -> out_valid is 0 immediately; in_ready = 1; a fresh frame then yields the exact scenario-1 output.
- W=2, H=2, pixels 9,3,7,1:
  - Output columns: (9,9,7), (3,3,1), (9,7,7), (3,1,1).
